mux_4to1: RTL and testbench

- 4:1 selector: routes one of four data inputs D0..D3 to output Y, chosen by the 2-bit select formed from S1 (MSB) and S0 (LSB).
- Y is purely combinational (zero latency), so it can sit in datapath steering logic without adding a cycle.
- A registered copy Y_q, clocked by clk and cleared by rst, is provided for consumers that need a timing-clean, flopped version.

---
 rtl/mux_4to1.sv | 37 +++
 tb/tb_mux_4to1.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1.sv
// 4:1 selector: combinational Y = D[{S1,S0}], plus a registered copy Y_q.
// Y has zero latency; Y_q lags Y by one clk cycle and clears asynchronously on rst.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q
);

  // An unknown select propagates X rather than silently falling back to D0.
  always_comb begin
    case ({S1, S0})
      2'b00:   Y = D0;
      2'b01:   Y = D1;
      2'b10:   Y = D2;
      2'b11:   Y = D3;
      default: Y = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q <= '0;
    end else begin
      Y_q <= Y;
    end
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1 at WIDTH=1 (hand-computed vectors) and WIDTH=8 (model-compared).
module tb_mux_4to1;

  logic       clk;
  logic       rst;
  logic       done;
  int         checks;
  int         failures;

  // WIDTH=1 instance, driven by directed vectors
  logic       s1_a;
  logic       s0_a;
  logic       d1 [4];
  logic       y1;
  logic       y_q1;

  // WIDTH=8 instance, compared against the model every cycle
  logic [1:0] sel8;
  logic [7:0] d8 [4];
  logic [7:0] y8;
  logic [7:0] y_q8;

  // registered-path model state
  logic [7:0] last_y;
  logic       q_valid;

  mux_4to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .S1(s1_a), .S0(s0_a),
    .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
    .Y(y1), .Y_q(y_q1)
  );

  mux_4to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .S1(sel8[1]), .S0(sel8[0]),
    .D0(d8[0]), .D1(d8[1]), .D2(d8[2]), .D3(d8[3]),
    .Y(y8), .Y_q(y_q8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_sel1(input int s);
    s1_a = s[1];
    s0_a = s[0];
  endtask

  // Model: Y is the selected input; Y_q is the Y seen at the last clock edge
  // taken while out of reset, or zero if none since reset.
  function automatic logic [7:0] model_y();
    return d8[sel8];
  endfunction

  always @(posedge rst) q_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q_valid = 1'b0;
    end else begin
      last_y  = model_y();
      q_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("y8_model", y8, model_y());
    chk("y_q8_model", y_q8, (q_valid && !rst) ? last_y : 8'h00);
  end

  // WIDTH=8 stimulus: literal-pinned table first, then random vectors.
  initial begin
    logic [7:0] tbl_exp [4];
    tbl_exp[0] = 8'hA5;
    tbl_exp[1] = 8'h3C;
    tbl_exp[2] = 8'h0F;
    tbl_exp[3] = 8'hF0;
    sel8  = 2'b00;
    d8[0] = 8'h00; d8[1] = 8'h00; d8[2] = 8'h00; d8[3] = 8'h00;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      #1;
      d8[0] = 8'hA5; d8[1] = 8'h3C; d8[2] = 8'h0F; d8[3] = 8'hF0;
      sel8  = 2'(s);
      #4;
      chk("y8_literal", y8, tbl_exp[s]);
    end
    while (!done) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 4; k++) d8[k] = 8'($urandom);
      sel8 = 2'($urandom_range(0, 3));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    done     = 1'b0;
    checks   = 0;
    failures = 0;
    q_valid  = 1'b0;
    last_y   = 8'h00;
    rst      = 1'b1;
    set_sel1(0);
    for (int k = 0; k < 4; k++) d1[k] = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_y_q1", {7'b0, y_q1}, 8'h00);
    chk("reset_y_q8", y_q8, 8'h00);
    rst = 1'b0;

    // one-hot routing
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) d1[k] = (k == i);
      set_sel1(i);
      #10;
      chk("one_hot", {7'b0, y1}, 8'h01);
    end

    // all high, select sweep
    for (int k = 0; k < 4; k++) d1[k] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sel1(i);
      #10;
      chk("all_high", {7'b0, y1}, 8'h01);
    end

    // isolation of unselected inputs
    set_sel1(1);
    d1[0] = 1'b0; d1[1] = 1'b0; d1[2] = 1'b0; d1[3] = 1'b0;
    #1;
    for (int t = 0; t < 6; t++) begin
      d1[0] = ~d1[0];
      if (t % 2 == 1) d1[2] = ~d1[2];
      if (t % 3 == 2) d1[3] = ~d1[3];
      #1;
      chk("isolation", {7'b0, y1}, 8'h00);
    end
    d1[1] = 1'b1;
    #1;
    chk("isolation_d1_rise", {7'b0, y1}, 8'h01);

    // exhaustive WIDTH=1: pattern bit k drives Dk, expected is bit sel of the pattern
    d1[0] = 1'b0; d1[1] = 1'b1; d1[2] = 1'b1; d1[3] = 1'b0;
    set_sel1(3);
    #1;
    chk("exh_literal_p6_s3", {7'b0, y1}, 8'h00);
    set_sel1(2);
    #1;
    chk("exh_literal_p6_s2", {7'b0, y1}, 8'h01);
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 16; p++) begin
        for (int k = 0; k < 4; k++) d1[k] = p[k];
        set_sel1(s);
        #1;
        chk("exhaustive_w1", {7'b0, y1}, 8'((p >> s) & 1));
      end
    end

    // registered path: async assert mid-cycle, then first edge after release
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_y_q1", {7'b0, y_q1}, 8'h00);
    set_sel1(2);
    d1[0] = 1'b0; d1[1] = 1'b0; d1[2] = 1'b1; d1[3] = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("y_q1_before_edge", {7'b0, y_q1}, 8'h00);
    chk("y1_sel2", {7'b0, y1}, 8'h01);
    @(posedge clk);
    #1;
    chk("y_q1_after_edge", {7'b0, y_q1}, 8'h01);

    // reset mid-operation: Y_q clears at once, Y keeps following inputs
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midop_y_q1", {7'b0, y_q1}, 8'h00);
    chk("midop_y1", {7'b0, y1}, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    chk("midop_released_y_q1", {7'b0, y_q1}, 8'h00);
    @(posedge clk);
    #1;
    chk("midop_recover_y_q1", {7'b0, y_q1}, 8'h01);

    // let the WIDTH=8 random traffic run against the model
    repeat (200) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
